// File: rtl/line_read_responder_pkg.sv
// Shared types for the line-read responder: physical address, byte width and
// the line-fill state encoding.
package line_read_responder_pkg;

    localparam int BYTE_WIDTH  = 8;
    localparam int PADDR_WIDTH = 32;

    typedef logic [PADDR_WIDTH-1:0] paddr_t;

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        BusRead = 2'd1,
        Done    = 2'd2
    } line_read_state_t;

    // Clears the within-line offset bits so word offsets never carry upward.
    function automatic paddr_t line_base(input paddr_t addr, input int unsigned line_size);
        return addr & ~(paddr_t'(line_size) - paddr_t'(1));
    endfunction

endpackage

// File: rtl/line_read_responder.sv
// Memory-side responder: turns one cache line read into WORD_COUNT sequential
// word reads on a narrower bus and returns the assembled line with a done pulse.
module line_read_responder
    import line_read_responder_pkg::*;
#(
    parameter int  LINE_SIZE  = 8,
    parameter int  WORD_WIDTH = 32,
    localparam int LINE_WIDTH = LINE_SIZE * BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  paddr_t                memAddr,
    input  logic                  memReadEnable,
    output logic                  memReadDone,
    output logic [LINE_WIDTH-1:0] memReadValue,
    output paddr_t                busAddr,
    output logic                  busReadEnable,
    input  logic                  busReadDone,
    input  logic [WORD_WIDTH-1:0] busReadValue
);

    localparam int WORD_COUNT = LINE_WIDTH / WORD_WIDTH;
    localparam int CNT_W      = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam paddr_t            WORD_BYTES = paddr_t'(WORD_WIDTH / BYTE_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_WORD  = CNT_W'(WORD_COUNT - 1);

    line_read_state_t state_r;
    logic [CNT_W-1:0] word_idx_r;

    // Line-fill sequencer; busAddr doubles as the running word address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= Idle;
            word_idx_r    <= '0;
            memReadDone   <= 1'b0;
            memReadValue  <= '0;
            busAddr       <= '0;
            busReadEnable <= 1'b0;
        end else begin
            case (state_r)
                Idle: begin
                    memReadDone <= 1'b0;
                    if (memReadEnable) begin
                        busAddr       <= line_base(memAddr, LINE_SIZE);
                        busReadEnable <= 1'b1;
                        word_idx_r    <= '0;
                        state_r       <= BusRead;
                    end
                end
                BusRead: begin
                    if (busReadDone) begin
                        for (int w = 0; w < WORD_COUNT; w++) begin
                            if (word_idx_r == CNT_W'(w)) begin
                                memReadValue[w*WORD_WIDTH +: WORD_WIDTH] <= busReadValue;
                            end
                        end
                        if (word_idx_r == LAST_WORD) begin
                            busReadEnable <= 1'b0;
                            memReadDone   <= 1'b1;
                            state_r       <= Done;
                        end else begin
                            word_idx_r <= word_idx_r + CNT_W'(1);
                            busAddr    <= busAddr + WORD_BYTES;
                        end
                    end
                end
                Done: begin
                    // Never re-accept here: a held request would be served twice.
                    memReadDone <= 1'b0;
                    state_r     <= Idle;
                end
                default: begin
                    state_r       <= Idle;
                    word_idx_r    <= '0;
                    memReadDone   <= 1'b0;
                    busReadEnable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_read_responder.sv
// Scoreboard bench: driver issues line reads and queues expected lines and bus
// addresses; a bus model and a done monitor compare independently.
module tb_line_read_responder;
    import line_read_responder_pkg::*;

    localparam int LINE_SIZE  = 8;
    localparam int WORD_WIDTH = 32;
    localparam int LW         = LINE_SIZE * BYTE_WIDTH;
    localparam int WC         = LW / WORD_WIDTH;

    typedef struct {
        logic [LW-1:0] line;
        int            cyc;
    } exp_t;

    logic                  clk;
    logic                  rst;
    paddr_t                memAddr;
    logic                  memReadEnable;
    logic                  memReadDone;
    logic [LW-1:0]         memReadValue;
    paddr_t                busAddr;
    logic                  busReadEnable;
    logic                  busReadDone;
    logic [WORD_WIDTH-1:0] busReadValue;

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    exp_t   exp_q[$];
    paddr_t exp_addr_q[$];
    int     lat_q[$];
    bit     bus_hold = 1'b0;
    logic [WORD_WIDTH-1:0] mem[paddr_t];

    line_read_responder #(
        .LINE_SIZE (LINE_SIZE),
        .WORD_WIDTH(WORD_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .memAddr      (memAddr),
        .memReadEnable(memReadEnable),
        .memReadDone  (memReadDone),
        .memReadValue (memReadValue),
        .busAddr      (busAddr),
        .busReadEnable(busReadEnable),
        .busReadDone  (busReadDone),
        .busReadValue (busReadValue)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic logic [WORD_WIDTH-1:0] model_word(input paddr_t a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic paddr_t model_base(input paddr_t a);
        return a - (a % LINE_SIZE);
    endfunction

    function automatic logic [LW-1:0] model_line(input paddr_t a);
        logic [LW-1:0] l;
        for (int i = 0; i < WC; i++) begin
            l[i*WORD_WIDTH +: WORD_WIDTH] = model_word(model_base(a) + paddr_t'(i * (WORD_WIDTH / 8)));
        end
        return l;
    endfunction

    // Word-bus responder: latency per word from lat_q, else random 1..4.
    initial begin
        bit     active;
        int     wait_left;
        paddr_t held;
        active       = 1'b0;
        wait_left    = 0;
        held         = '0;
        busReadDone  = 1'b0;
        busReadValue = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_hold) begin
                active = 1'b0;
            end else begin
                busReadDone = 1'b0;
                if (rst || !busReadEnable) begin
                    active = 1'b0;
                end else begin
                    if (!active) begin
                        active    = 1'b1;
                        held      = busAddr;
                        wait_left = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom_range(1, 4));
                        if (exp_addr_q.size() == 0) fail_now("unexpected_bus_read");
                        else check("bus_addr", 64'(busAddr), 64'(exp_addr_q.pop_front()));
                    end else begin
                        check("bus_addr_stable", 64'(busAddr), 64'(held));
                    end
                    wait_left--;
                    if (wait_left <= 0) begin
                        busReadDone  = 1'b1;
                        busReadValue = model_word(held);
                        active       = 1'b0;
                    end
                end
            end
        end
    end

    // Done monitor: every memReadDone pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && memReadDone) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    check("line_value", 64'(memReadValue), 64'(e.line));
                    if (e.cyc >= 0) check("done_latency", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic do_fill(input paddr_t a, input logic [LW-1:0] line, input bit timed,
                           input bit keep, input bit move, input paddr_t alt);
        exp_t e;
        bit   seen;
        memAddr       = a;
        memReadEnable = 1'b1;
        e.line        = line;
        e.cyc         = timed ? cyc + 1 + WC : -1;
        exp_q.push_back(e);
        for (int i = 0; i < WC; i++) exp_addr_q.push_back(model_base(a) + paddr_t'(i * (WORD_WIDTH / 8)));
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (move && k == 1) memAddr = alt;
            if (memReadDone) seen = 1'b1;
        end
        if (!seen) fail_now("done_timeout");
        @(posedge clk);
        #1;
        if (!keep) memReadEnable = 1'b0;
    endtask

    initial begin
        logic [LW-1:0] held_line;
        paddr_t        ra;
        bit            keep;
        rst           = 1'b1;
        memAddr       = '0;
        memReadEnable = 1'b0;

        // 1: reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 64'(memReadDone), 64'd0);
        check("rst_bus_en", 64'(busReadEnable), 64'd0);
        check("rst_line", 64'(memReadValue), 64'd0);
        check("rst_bus_addr", 64'(busAddr), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 2: single-latency fill with known words and exact timing
        mem[32'h0000_1000] = 32'hAAAA_0001;
        mem[32'h0000_1004] = 32'hBBBB_0002;
        lat_q.push_back(1);
        lat_q.push_back(1);
        do_fill(32'h0000_1004, 64'hBBBB_0002_AAAA_0001, 1'b1, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("line_stable", 64'(memReadValue), 64'hBBBB_0002_AAAA_0001);

        // 3: variable per-word latency
        lat_q.push_back(5);
        lat_q.push_back(2);
        do_fill(32'h0000_1100, model_line(32'h0000_1100), 1'b0, 1'b0, 1'b0, '0);

        // 4: request held past done with a new address
        do_fill(32'h0000_1000, model_line(32'h0000_1000), 1'b0, 1'b1, 1'b0, '0);
        do_fill(32'h0000_2000, model_line(32'h0000_2000), 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;

        // 5: reset after word 0, then a stale bus done in Idle
        lat_q.push_back(1);
        lat_q.push_back(6);
        memAddr       = 32'h0000_5000;
        memReadEnable = 1'b1;
        exp_addr_q.push_back(32'h0000_5000);
        exp_addr_q.push_back(32'h0000_5004);
        begin
            bit hit;
            hit = 1'b0;
            for (int k = 0; k < 50 && !hit; k++) begin
                @(posedge clk);
                #1;
                if (busReadEnable && busAddr == 32'h0000_5004) hit = 1'b1;
            end
            if (!hit) fail_now("word1_timeout");
        end
        rst           = 1'b1;
        memReadEnable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_addr_q.delete();
        lat_q.delete();
        check("mid_rst_bus_en", 64'(busReadEnable), 64'd0);
        check("mid_rst_line", 64'(memReadValue), 64'd0);
        bus_hold     = 1'b1;
        busReadDone  = 1'b1;
        busReadValue = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        busReadDone = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stale_done_bus_en", 64'(busReadEnable), 64'd0);
        check("stale_done_line", 64'(memReadValue), 64'd0);
        bus_hold = 1'b0;
        do_fill(32'h0000_6008, model_line(32'h0000_6008), 1'b0, 1'b0, 1'b0, '0);

        // 6: stray bus done in Idle, then memAddr moves mid-fill
        held_line    = memReadValue;
        bus_hold     = 1'b1;
        busReadDone  = 1'b1;
        busReadValue = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        busReadDone = 1'b0;
        @(posedge clk);
        #1;
        check("stray_bus_en", 64'(busReadEnable), 64'd0);
        check("stray_line", 64'(memReadValue), 64'(held_line));
        bus_hold = 1'b0;
        do_fill(32'h0000_3008, model_line(32'h0000_3008), 1'b0, 1'b0, 1'b1, 32'h0000_4000);

        // Random fills, some back-to-back
        for (int n = 0; n < 25; n++) begin
            ra   = paddr_t'($urandom) & 32'h000F_FFFF;
            keep = (n < 24) && ($urandom_range(0, 3) == 0);
            do_fill(ra, model_line(ra), 1'b0, keep, 1'b0, '0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("lines_left", 64'(exp_q.size()), 64'd0);
        check("addrs_left", 64'(exp_addr_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
